mtx_seq_ctrl: RTL and testbench

Multi-cycle sequencer for matrix-extension (`Mtype`) instructions. It accepts one matrix instruction from the EX stage and drives the shared data-memory port and the matrix MAC datapath for the whole operation. It holds the scalar pipeline stalled through `mtx_busy` until the operation retires. It sits beside the hazard/stall logic, which ORs `mtx_busy` into the IF/ID/EX stall enables.

---
 rtl/mtx_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mtx_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_seq_ctrl.sv
// Multi-cycle sequencer for matrix load/store/multiply instructions.
// Optional busy-cycle counter is built only when MTX_PERF_CNT_EN is defined.
module mtx_seq_ctrl #(
    parameter int DIM = 4,
    parameter int DW  = 32,
    parameter int AW  = 32,
    localparam int LW = $clog2(DIM),
    localparam int EW = 2 * LW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          issue_valid,
    input  logic [2:0]    issue_func3,
    input  logic [AW-1:0] issue_base,
    output logic          mtx_busy,
    output logic          mtx_done,
    output logic          mtx_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          mreg_we,
    output logic [EW-1:0] mreg_idx,
    output logic [DW-1:0] mreg_wdata,
    input  logic [DW-1:0] mreg_rdata,
    output logic          mac_en,
    output logic [LW-1:0] mac_i,
    output logic [LW-1:0] mac_j,
    output logic [LW-1:0] mac_k,
    output logic          mac_first,
    output logic          mac_last,
    output logic [31:0]   perf_busy_cycles
);

    localparam logic [2:0] F3_MLD  = 3'b001;
    localparam logic [2:0] F3_MST  = 3'b011;
    localparam logic [2:0] F3_MMUL = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_REQ,
        MUL,
        DONE
    } state_t;

    state_t            state_reg;
    logic [EW-1:0]     e_reg;
    logic [AW-1:0]     base_reg;
    logic [3*LW-1:0]   mul_cnt_reg;
    logic              err_reg;

    logic issue_legal;
    logic in_mem_op;
    logic e_last;

    assign issue_legal = (issue_func3 == F3_MLD) || (issue_func3 == F3_MST) ||
                         (issue_func3 == F3_MMUL);
    assign in_mem_op   = (state_reg == LD_REQ) || (state_reg == LD_WAIT) || (state_reg == ST_REQ);
    assign e_last      = &e_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            e_reg       <= '0;
            base_reg    <= '0;
            mul_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (issue_valid) begin
                        case (issue_func3)
                            F3_MLD: begin
                                base_reg  <= issue_base;
                                e_reg     <= '0;
                                state_reg <= LD_REQ;
                            end
                            F3_MST: begin
                                base_reg  <= issue_base;
                                e_reg     <= '0;
                                state_reg <= ST_REQ;
                            end
                            F3_MMUL: begin
                                mul_cnt_reg <= '0;
                                state_reg   <= MUL;
                            end
                            default: err_reg <= 1'b1;
                        endcase
                    end
                end
                LD_REQ: begin
                    if (mem_gnt) state_reg <= LD_WAIT;
                end
                LD_WAIT: begin
                    if (mem_rvalid) begin
                        if (e_last) begin
                            state_reg <= DONE;
                        end else begin
                            e_reg     <= e_reg + EW'(1);
                            state_reg <= LD_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        if (e_last) state_reg <= DONE;
                        else        e_reg     <= e_reg + EW'(1);
                    end
                end
                MUL: begin
                    // {i,j,k} as one counter gives k innermost, then j, then i
                    if (&mul_cnt_reg) state_reg   <= DONE;
                    else              mul_cnt_reg <= mul_cnt_reg + (3*LW)'(1);
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Busy is 0 in DONE so the pipeline advances on the retire cycle
    assign mtx_busy = rstn && (((state_reg != IDLE) && (state_reg != DONE)) ||
                               ((state_reg == IDLE) && issue_valid && issue_legal));
    assign mtx_done = (state_reg == DONE);
    assign mtx_err  = err_reg;

    assign mem_req   = (state_reg == LD_REQ) || (state_reg == ST_REQ);
    assign mem_we    = (state_reg == ST_REQ);
    assign mem_addr  = mem_req ? (base_reg + AW'({e_reg, 2'b00})) : '0;
    assign mem_wdata = mem_we ? mreg_rdata : '0;

    assign mreg_idx   = in_mem_op ? e_reg : '0;
    assign mreg_we    = (state_reg == LD_WAIT) && mem_rvalid;
    assign mreg_wdata = mreg_we ? mem_rdata : '0;

    assign mac_en    = (state_reg == MUL);
    assign mac_i     = mac_en ? mul_cnt_reg[3*LW-1:2*LW] : '0;
    assign mac_j     = mac_en ? mul_cnt_reg[2*LW-1:LW]   : '0;
    assign mac_k     = mac_en ? mul_cnt_reg[LW-1:0]      : '0;
    assign mac_first = mac_en && (mul_cnt_reg[LW-1:0] == '0);
    assign mac_last  = mac_en && (&mul_cnt_reg[LW-1:0]);

`ifdef MTX_PERF_CNT_EN
    // Counts cycles spent working an operation (the combinational issue cycle is not one)
    logic        working;
    logic [31:0] perf_reg;

    assign working = in_mem_op || (state_reg == MUL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_reg <= '0;
        end else if (working && (perf_reg != '1)) begin
            perf_reg <= perf_reg + 32'd1;
        end
    end

    assign perf_busy_cycles = perf_reg;
`else
    assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_mtx_seq_ctrl.sv
// Scoreboard bench for mtx_seq_ctrl: memory responder, matrix-register model,
// expected memory/mreg/MAC traffic queued at issue and checked as it appears.
module tb_mtx_seq_ctrl;
    localparam int DIM = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NE  = DIM * DIM;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          issue_valid = 1'b0;
    logic [2:0]    issue_func3 = '0;
    logic [AW-1:0] issue_base = '0;
    logic          mtx_busy, mtx_done, mtx_err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mreg_we;
    logic [3:0]    mreg_idx;
    logic [DW-1:0] mreg_wdata;
    logic [DW-1:0] mreg_rdata;
    logic          mac_en, mac_first, mac_last;
    logic [1:0]    mac_i, mac_j, mac_k;
    logic [31:0]   perf_busy_cycles;

    always #5 clk = ~clk;

    mtx_seq_ctrl #(.DIM(DIM), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .issue_valid(issue_valid), .issue_func3(issue_func3), .issue_base(issue_base),
        .mtx_busy(mtx_busy), .mtx_done(mtx_done), .mtx_err(mtx_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mreg_we(mreg_we), .mreg_idx(mreg_idx), .mreg_wdata(mreg_wdata), .mreg_rdata(mreg_rdata),
        .mac_en(mac_en), .mac_i(mac_i), .mac_j(mac_j), .mac_k(mac_k),
        .mac_first(mac_first), .mac_last(mac_last),
        .perf_busy_cycles(perf_busy_cycles)
    );

    // Matrix register file model
    logic [DW-1:0] mreg_mem [NE];
    assign mreg_rdata = mreg_mem[mreg_idx];
    always @(posedge clk) if (mreg_we) mreg_mem[mreg_idx] <= mreg_wdata;

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } mem_txn_t;
    typedef struct packed { logic [3:0] idx; logic [31:0] data; } reg_txn_t;

    mem_txn_t   exp_mem_q[$];
    reg_txn_t   exp_reg_q[$];
    logic [5:0] exp_mac_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and monitor-owned state
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          busy_acc = 0, err_cnt = 0, done_cnt = 0, done_cyc = 0;
    int          mac_cnt = 0, first_cnt = 0, last_cnt = 0;
    logic [5:0]  last_ijk = '0;
    logic        rd_pending = 1'b0;
    logic [31:0] rd_addr = '0;
    int          stall_cnt = 0;
    logic        stall_used = 1'b0;
    logic        held_valid = 1'b0;
    logic [64:0] held = '0;
    mem_txn_t    m;
    reg_txn_t    r;
    logic [5:0]  x;

    // Stimulus-owned knobs
    logic        stall_en = 1'b0;
    logic [31:0] stall_addr = '0;
    logic        block_en = 1'b0;
    logic [31:0] block_addr = '0;
    logic        manual_rv = 1'b0;
    int          issue_cyc = 0;

    // Memory responder (drive at negedge) and monitor (sample 1 time unit later)
    always @(negedge clk) begin
        if (!rstn) begin
            rd_pending = 1'b0;
            stall_cnt  = 0;
        end
        if (manual_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
        end else if (rd_pending && !(block_en && rd_addr == block_addr)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_addr;
            rd_pending = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        if (!stall_en) stall_used = 1'b0;
        else if (!stall_used && mem_req && mem_we && mem_addr == stall_addr) begin
            stall_cnt  = 3;
            stall_used = 1'b1;
        end
        mem_gnt = mem_req && (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        #1;
        if (!rstn) begin
            exp_mem_q.delete();
            exp_reg_q.delete();
            exp_mac_q.delete();
        end
        if (mtx_busy) busy_acc++;
        if (mtx_err) err_cnt++;
        if (mtx_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_req && mem_gnt) begin
            check("mem txn queued", exp_mem_q.size() > 0, 1);
            if (exp_mem_q.size() > 0) begin
                m = exp_mem_q.pop_front();
                check("mem we", mem_we, m.we);
                check("mem addr", mem_addr, m.addr);
                if (m.we) check("mem wdata", mem_wdata, m.data);
            end
            if (!mem_we) begin
                rd_pending = 1'b1;
                rd_addr    = mem_addr;
            end
            held_valid = 1'b0;
        end else if (mem_req) begin
            if (held_valid) check("req stable", {mem_we, mem_addr, mem_wdata}, held);
            held       = {mem_we, mem_addr, mem_wdata};
            held_valid = 1'b1;
        end else begin
            held_valid = 1'b0;
        end
        if (mreg_we) begin
            check("mreg txn queued", exp_reg_q.size() > 0, 1);
            if (exp_reg_q.size() > 0) begin
                r = exp_reg_q.pop_front();
                check("mreg idx", mreg_idx, r.idx);
                check("mreg data", mreg_wdata, r.data);
            end
        end
        if (mac_en) begin
            mac_cnt++;
            if (mac_first) first_cnt++;
            if (mac_last) last_cnt++;
            last_ijk = {mac_i, mac_j, mac_k};
            check("mac queued", exp_mac_q.size() > 0, 1);
            if (exp_mac_q.size() > 0) begin
                x = exp_mac_q.pop_front();
                check("mac ijk", {mac_i, mac_j, mac_k}, x);
                check("mac first/last", {mac_first, mac_last}, {x[1:0] == 2'd0, x[1:0] == 2'd3});
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] base, input logic exp_busy);
        @(negedge clk);
        issue_valid = 1'b1;
        issue_func3 = f3;
        issue_base  = base;
        issue_cyc   = cyc;
        #2 check("issue busy", mtx_busy, exp_busy);
        @(negedge clk);
        issue_valid = 1'b0;
        issue_func3 = '0;
        issue_base  = '0;
    endtask

    task automatic wait_done(input string tag, input int bound, input int exp_lat);
        int   start;
        logic seen;
        start = done_cnt;
        seen  = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(negedge clk);
            #2;
            if (done_cnt != start) seen = 1'b1;
        end
        check({tag, " done seen"}, seen, 1'b1);
        if (seen) check({tag, " latency"}, done_cyc - issue_cyc, exp_lat);
    endtask

    task automatic push_mld(input logic [31:0] base);
        for (int e = 0; e < NE; e++) begin
            exp_mem_q.push_back('{we: 1'b0, addr: base + 32'(4 * e), data: 32'h0});
            exp_reg_q.push_back('{idx: 4'(e), data: base + 32'(4 * e)});
        end
    endtask

    task automatic push_mmul();
        for (int n = 0; n < DIM * DIM * DIM; n++)
            exp_mac_q.push_back({2'(n / 16), 2'((n / 4) % 4), 2'(n % 4)});
    endtask

    initial begin
        int   b0, e0, d0, f0, l0, mc0;
        logic reached;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("reset flags", {mtx_busy, mtx_done, mtx_err, mem_req, mem_we, mreg_we,
                              mac_en, mac_first, mac_last}, 9'h0);
        check("reset addr/idx", {mem_addr, mem_wdata, mreg_idx}, 68'h0);
        check("reset perf", perf_busy_cycles, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // MLD, zero-wait memory returning data = address
        push_mld(32'h100);
        b0 = busy_acc;
        issue(3'b001, 32'h100, 1'b1);
        wait_done("mld", 60, 33);
        check("mld busy cycles", busy_acc - b0, 33);
        check("mld leftover", exp_mem_q.size() + exp_reg_q.size(), 0);

        // MST with a 3-cycle grant stall on element 5; data = what MLD loaded
        stall_en   = 1'b1;
        stall_addr = 32'h214;
        for (int e = 0; e < NE; e++)
            exp_mem_q.push_back('{we: 1'b1, addr: 32'h200 + 32'(4 * e), data: 32'h100 + 32'(4 * e)});
        issue(3'b011, 32'h200, 1'b1);
        wait_done("mst", 60, 20);
        check("mst stall hit", stall_used, 1'b1);
        check("mst leftover", exp_mem_q.size(), 0);
        stall_en = 1'b0;

        // MMUL
        f0 = first_cnt; l0 = last_cnt; mc0 = mac_cnt;
        push_mmul();
        issue(3'b100, 32'h0, 1'b1);
        wait_done("mmul", 100, 65);
        check("mmul mac cycles", mac_cnt - mc0, 64);
        check("mmul first count", first_cnt - f0, 16);
        check("mmul last count", last_cnt - l0, 16);
        check("mmul final ijk", last_ijk, 6'h3F);
        check("mmul mac_en in done", mac_en, 1'b0);

        // Illegal func3
        e0 = err_cnt; d0 = done_cnt; b0 = busy_acc;
        issue(3'b010, 32'h0, 1'b0);
        @(negedge clk);
        #2;
        check("illegal err pulses", err_cnt - e0, 1);
        check("illegal err cleared", mtx_err, 1'b0);
        check("illegal no done", done_cnt - d0, 0);
        check("illegal no busy", busy_acc - b0, 0);
        check("illegal idle", {mem_req, mac_en, mtx_busy}, 3'b000);

        // Reset while waiting for the read of element 7
        block_en   = 1'b1;
        block_addr = 32'h31C;
        push_mld(32'h300);
        issue(3'b001, 32'h300, 1'b1);
        reached = 1'b0;
        for (int n = 0; n < 60 && !reached; n++) begin
            @(negedge clk);
            #2;
            if (rd_pending && rd_addr == 32'h31C) reached = 1'b1;
        end
        check("rst reached e7 wait", reached, 1'b1);
        @(negedge clk);
        rstn = 1'b0;
        #2;
        check("rst mid flags", {mtx_busy, mtx_done, mtx_err, mem_req, mem_we, mreg_we,
                                mac_en, mac_first, mac_last}, 9'h0);
        check("rst mid addr/idx", {mem_addr, mem_wdata, mreg_idx}, 68'h0);
        check("rst mid perf", perf_busy_cycles, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        manual_rv = 1'b1;
        @(negedge clk);
        #2;
        check("stale rvalid ignored", {mreg_we, mreg_wdata}, 33'h0);
        check("stale idle", {mtx_busy, mem_req, mtx_done}, 3'b000);
        @(posedge clk);
        manual_rv = 1'b0;
        block_en  = 1'b0;

        // MMUL then MST (zero-wait) for the busy-cycle counter
        push_mmul();
        issue(3'b100, 32'h0, 1'b1);
        wait_done("perf mmul", 100, 65);
        for (int e = 0; e < NE; e++)
            exp_mem_q.push_back('{we: 1'b1, addr: 32'h400 + 32'(4 * e),
                                  data: (e < 7) ? 32'h300 + 32'(4 * e) : 32'h100 + 32'(4 * e)});
        issue(3'b011, 32'h400, 1'b1);
        wait_done("perf mst", 60, 17);
        check("perf leftover", exp_mem_q.size() + exp_mac_q.size(), 0);
`ifdef MTX_PERF_CNT_EN
        check("perf busy cycles", perf_busy_cycles, 32'd80);
`else
        check("perf busy cycles", perf_busy_cycles, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
